// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   arb_state_t  - arbiter FSM encoding (ST_IDLE, ST_WAIT)
//   idx_width()  - width of a requester index / round-robin pointer
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  // Index width for n requesters. Kept at 1 or more so a two-way
  // arbiter still gets a real pointer bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// ---------------------------------------------------------------------------
// uart_rr_arbiter
// Purely combinational N-way round-robin pick. The search starts at the
// requester after ptr and wraps modulo N, so the last owner has the lowest
// priority.
// Ports:
//   req       in  N    request vector
//   ptr       in  IW   index of the last owner
//   onehot    out N    one-hot winner (all zero when nothing requests)
//   idx       out IW   winner index (0 when nothing requests)
//   any_valid out 1    at least one request present
// ---------------------------------------------------------------------------
module uart_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any_valid
);

  always_comb begin
    int cand;
    cand      = 0;
    any_valid = 1'b0;
    idx       = '0;
    onehot    = '0;
    // Offsets 1..N visit ptr+1 first and the last owner itself last.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any_valid && req[cand]) begin
        any_valid = 1'b1;
        idx       = IW'(cand);
      end
    end
    if (any_valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx among N byte producers. Round-robin, one byte per grant:
// the winner's byte is captured, tx_start is pulsed, ownership is held until
// tx_done, then the winner gets a done pulse.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a WAIT cycle counter aborts a transfer that has not seen
//   tx_done after TIMEOUT_CYCLES cycles (timeout_err pulse, no done pulse).
//   When undefined, WAIT lasts until tx_done and timeout_err is tied 0.
//
// Handshake: req[i] is a level held until gnt[i]; req_data lane i is valid
// while req[i] is high. gnt[i] is a 1-cycle pulse meaning the byte was
// captured; the requester must drop req[i] (or present its next byte) on the
// following cycle, since a req still high when the arbiter returns to IDLE is
// a new byte. done[i] is a 1-cycle pulse once that byte has left the UART.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous active-low reset
//   req          in   N        per-requester byte request
//   req_data     in   N*8      requester i byte at [8*i+7:8*i]
//   gnt          out  N        one-hot capture pulse
//   done         out  N        one-hot completion pulse
//   grant_id     out  IW       index of current/last owner
//   busy         out  1        transfer in flight
//   tx_start     out  1        uart_tx start pulse
//   tx_data      out  8        uart_tx data, stable until next capture
//   tx_done      in   1        uart_tx frame complete
//   timeout_err  out  1        abort pulse (0 without the macro)
//   state        out  state    FSM state, for observation
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*8-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [IW-1:0]  grant_id,
  output logic           busy,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_done,
  output logic           timeout_err,
  output arb_state_t     state
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("uart_tx_arbiter: N must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [IW-1:0] ptr;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  uart_rr_arbiter #(.N(N)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ptr      <= IW'(N - 1);
      gnt      <= '0;
      done     <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      // Pulse outputs default low; the cases below raise them for one cycle.
      gnt      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          // tx_done here is stale (or from a frame cut off by reset): ignored.
          if (pick_any) begin
            gnt      <= pick_onehot;
            tx_data  <= req_data[{pick_idx, 3'b000} +: 8];
            tx_start <= 1'b1;
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // req is not looked at while a frame is in flight.
          if (tx_done) begin
            done[grant_id] <= 1'b1;
            busy           <= 1'b0;
            ptr            <= grant_id;
            state          <= ST_IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // The counter reaches TIMEOUT_CYCLES on this edge; a tx_done
          // arriving on the same edge takes the normal path above.
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            ptr         <= grant_id;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N=4). Expected grants {id, byte}
// are queued as stimulus is applied; a monitor pops and compares every
// gnt/tx_start pulse. Scenario tasks check done/busy/reset behaviour inline.
// Build with +define+UART_ARB_TIMEOUT_EN to exercise the abort path
// (TIMEOUT_CYCLES=100).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = IW + 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           timeout_err;
  arb_state_t     state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .grant_id    (grant_id),
    .busy        (busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .timeout_err (timeout_err),
    .state       (state)
  );

  int checks = 0;
  int passed = 0;
  int gnt_pulses = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [N-1:0] eg;
    if (rst && (gnt != '0 || tx_start)) begin
      gnt_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: gnt=%b id=%0d data=%h, expected no grant", gnt, grant_id, tx_data);
      end else begin
        e  = exp_q.pop_front();
        eg = '0;
        eg[e[W-1:8]] = 1'b1;
        if (gnt !== eg || tx_start !== 1'b1 || grant_id !== e[W-1:8] || tx_data !== e[7:0])
          $display("FAIL sb_grant: gnt=%b start=%b id=%0d data=%h, expected gnt=%b start=1 id=%0d data=%h",
                   gnt, tx_start, grant_id, tx_data, eg, e[W-1:8], e[7:0]);
        else
          passed++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Pulse tx_done for one edge and check the resulting done vector.
  task automatic finish_frame(input logic [N-1:0] exp_done, input string name);
    tx_done = 1'b1;
    tick();
    checks++;
    if (done !== exp_done || busy !== 1'b0)
      $display("FAIL %s: done=%b busy=%b, expected done=%b busy=0", name, done, busy, exp_done);
    else
      passed++;
    tx_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, tx_start, timeout_err, tx_data, grant_id} !== '0)
      $display("FAIL reset_outputs: gnt=%b done=%b busy=%b start=%b err=%b data=%h id=%0d, expected all zero",
               gnt, done, busy, tx_start, timeout_err, tx_data, grant_id);
    else passed++;
    checks++;
    if (state !== ST_IDLE) $display("FAIL reset_state: state=%0d, expected %0d", state, ST_IDLE);
    else passed++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    exp_q.push_back({2'd0, 8'hA5});
    tick();
    checks++;
    if (gnt !== 4'b0001 || tx_start !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1)
      $display("FAIL single_capture: gnt=%b start=%b data=%h busy=%b, expected 0001 1 a5 1",
               gnt, tx_start, tx_data, busy);
    else passed++;
    req = '0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL single_pulse_clear: gnt=%b start=%b busy=%b data=%h, expected 0000 0 1 a5",
               gnt, tx_start, busy, tx_data);
    else passed++;
    repeat (18) tick();
    finish_frame(4'b0001, "single_done");
    tick();
    checks++;
    if (done !== 4'b0000) $display("FAIL single_done_pulse: done=%b, expected 0000", done);
    else passed++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int p0;
    logic [IW-1:0] idv;
    logic [N-1:0]  ed;
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    p0 = gnt_pulses;
    for (int k = 0; k < 5; k++) begin
      idv = IW'(k % N);
      exp_q.push_back({idv, 8'h10 + 8'(k % N)});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idv = IW'(k % N);
      ed = '0;
      ed[idv] = 1'b1;
      wait_start(ok);
      checks++;
      if (!ok) $display("FAIL rr_start_timeout: byte %0d, no tx_start within 50 cycles", k);
      else passed++;
      repeat (9) tick();
      finish_frame(ed, "rr_done");
      if (k == 4) req = '0;
    end
    repeat (5) tick();
    checks++;
    if (gnt_pulses - p0 != 5 || exp_q.size() != 0)
      $display("FAIL rr_pulse_count: pulses=%0d pending=%0d, expected 5 and 0", gnt_pulses - p0, exp_q.size());
    else passed++;
  endtask

  task automatic test_skip_idle();
    bit ok;
    do_reset();
    req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    req = 4'b0001;
    exp_q.push_back({2'd0, 8'h30});
    tick();
    req = 4'b1010;
    exp_q.push_back({2'd1, 8'h31});
    exp_q.push_back({2'd3, 8'h33});
    repeat (4) tick();
    finish_frame(4'b0001, "skip_done0");
    wait_start(ok);
    checks++;
    if (!ok || grant_id !== 2'd1) $display("FAIL skip_grant1: ok=%0d id=%0d, expected 1 1", ok, grant_id);
    else passed++;
    req = 4'b1000;
    repeat (4) tick();
    finish_frame(4'b0010, "skip_done1");
    wait_start(ok);
    checks++;
    if (!ok || grant_id !== 2'd3) $display("FAIL skip_grant3: ok=%0d id=%0d, expected 1 3", ok, grant_id);
    else passed++;
    req = '0;
    repeat (4) tick();
    finish_frame(4'b1000, "skip_done3");
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    req_data = {8'h53, 8'h52, 8'h51, 8'h40};
    req = 4'b0001;
    exp_q.push_back({2'd0, 8'h40});
    tick();
    req = '0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || state !== ST_WAIT) $display("FAIL midrst_inflight: busy=%b state=%0d, expected 1 1", busy, state);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, tx_start, timeout_err, tx_data, grant_id} !== '0 || state !== ST_IDLE)
      $display("FAIL midrst_values: busy=%b data=%h id=%0d state=%0d, expected 0 00 0 0",
               busy, tx_data, grant_id, state);
    else passed++;
    tick();
    rst = 1'b1;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0) $display("FAIL midrst_stale_done: done=%b busy=%b, expected 0000 0", done, busy);
    else passed++;
    req = 4'b1010;
    exp_q.push_back({2'd1, 8'h51});
    wait_start(ok);
    req = '0;
    checks++;
    if (!ok || grant_id !== 2'd1) $display("FAIL midrst_regrant: ok=%0d id=%0d, expected 1 1", ok, grant_id);
    else passed++;
    repeat (3) tick();
    finish_frame(4'b0010, "midrst_done1");
  endtask

  task automatic test_timeout();
    bit ok;
    bit busy_dropped;
    bit err_seen;
    bit done_seen;
    int cyc;
    do_reset();
    req_data = {8'h63, 8'h62, 8'h61, 8'h60};
    req = 4'b0001;
    exp_q.push_back({2'd0, 8'h60});
    tick();
    req = 4'b0010;
`ifdef UART_ARB_TIMEOUT_EN
    exp_q.push_back({2'd1, 8'h61});
    cyc = 0;
    done_seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done != '0) done_seen = 1'b1;
      if (timeout_err) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc != TO || done_seen || busy !== 1'b0)
      $display("FAIL timeout_abort: after=%0d done_seen=%0d busy=%b, expected %0d 0 0", cyc, done_seen, busy, TO);
    else passed++;
    wait_start(ok);
    req = '0;
    checks++;
    if (!ok || grant_id !== 2'd1 || timeout_err !== 1'b0)
      $display("FAIL timeout_next: ok=%0d id=%0d err=%b, expected 1 1 0", ok, grant_id, timeout_err);
    else passed++;
    repeat (3) tick();
    finish_frame(4'b0010, "timeout_done1");
`else
    busy_dropped = 1'b0;
    err_seen = 1'b0;
    done_seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      cyc++;
      if (!busy) busy_dropped = 1'b1;
      if (timeout_err) err_seen = 1'b1;
      if (done != '0) done_seen = 1'b1;
    end
    checks++;
    if (busy_dropped || err_seen || done_seen)
      $display("FAIL hold_wait: cycles=%0d busy_dropped=%0d err=%0d done=%0d, expected 0 0 0",
               cyc, busy_dropped, err_seen, done_seen);
    else passed++;
    exp_q.push_back({2'd1, 8'h61});
    finish_frame(4'b0001, "hold_done0");
    wait_start(ok);
    req = '0;
    checks++;
    if (!ok || grant_id !== 2'd1) $display("FAIL hold_next: ok=%0d id=%0d, expected 1 1", ok, grant_id);
    else passed++;
    repeat (3) tick();
    finish_frame(4'b0010, "hold_done1");
`endif
  endtask

  task automatic test_idle_tx_done();
    do_reset();
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0 || state !== ST_IDLE || tx_start !== 1'b0)
      $display("FAIL idle_tx_done: done=%b busy=%b state=%0d start=%b, expected 0000 0 0 0",
               done, busy, state, tx_start);
    else passed++;
    tick();
    checks++;
    if (done !== 4'b0000) $display("FAIL idle_tx_done_late: done=%b, expected 0000", done);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip_idle();
    test_reset_mid_wait();
    test_timeout();
    test_idle_tx_done();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: pending=%0d, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
